board_ctl: RTL and testbench

BOARD_CTL -- requirements
Module: board_ctl

---
 rtl/board_ctl.sv | 130 +++++++++++++
 tb/tb_board_ctl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_ctl.sv
// Tic-tac-toe board controller: turns mouse clicks on a 3x3 grid into moves,
// alternates turns and reports a win or draw.
module board_ctl (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        mouse_left,
  input  logic        start_en,
  input  logic        choice_en,
  input  logic        first_color,
  output logic [8:0]  square,
  output logic [8:0]  square_color,
  output logic        turn,
  output logic        game_over,
  output logic        winner_valid,
  output logic        winner_color,
  output logic [2:0]  state
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] PLAY   = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] CHECK  = 3'd3;
  localparam logic [2:0] OVER   = 3'd4;

  logic       mouse_left_d;
  logic       click_q;
  logic [8:0] cell_q;
  logic [8:0] sel;
  logic [1:0] col_idx;
  logic [1:0] row_idx;
  logic       col_ok;
  logic       row_ok;
  logic [3:0] cell_idx;
  logic [8:0] mover_sq;
  logic       go_idle;

  function automatic logic has_line(input logic [8:0] b);
    return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
           (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
           (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
  endfunction

  // Positions on a grid line or off-screen leave col_ok/row_ok low, so they map to no square.
  always_comb begin
    col_idx = 2'd0;
    col_ok  = 1'b1;
    if (mouse_xpos <= 12'd339)                             col_idx = 2'd0;
    else if (mouse_xpos >= 12'd343 && mouse_xpos <= 12'd681)  col_idx = 2'd1;
    else if (mouse_xpos >= 12'd685 && mouse_xpos <= 12'd1023) col_idx = 2'd2;
    else                                                   col_ok  = 1'b0;

    row_idx = 2'd0;
    row_ok  = 1'b1;
    if (mouse_ypos <= 12'd251)                             row_idx = 2'd0;
    else if (mouse_ypos >= 12'd258 && mouse_ypos <= 12'd509)  row_idx = 2'd1;
    else if (mouse_ypos >= 12'd516 && mouse_ypos <= 12'd767)  row_idx = 2'd2;
    else                                                   row_ok  = 1'b0;

    cell_idx = {2'b00, row_idx} * 4'd3 + {2'b00, col_idx};
  end

  // Only the colour that just moved can have completed a line.
  assign mover_sq = turn ? (square & square_color) : (square & ~square_color);
  assign go_idle  = !start_en || choice_en;

  always_ff @(posedge pclk) begin
    if (rst) begin
      mouse_left_d <= 1'b0;
      click_q      <= 1'b0;
      cell_q       <= 9'd0;
      sel          <= 9'd0;
      state        <= IDLE;
      square       <= 9'd0;
      square_color <= 9'd0;
      turn         <= 1'b0;
      game_over    <= 1'b0;
      winner_valid <= 1'b0;
      winner_color <= 1'b0;
    end else begin
      mouse_left_d <= mouse_left;
      click_q      <= mouse_left & ~mouse_left_d;
      cell_q       <= (col_ok && row_ok) ? (9'd1 << cell_idx) : 9'd0;

      if (go_idle || state == IDLE) begin
        square       <= 9'd0;
        square_color <= 9'd0;
        turn         <= first_color;
        game_over    <= 1'b0;
        winner_valid <= 1'b0;
        winner_color <= 1'b0;
        state        <= go_idle ? IDLE : PLAY;
      end else begin
        case (state)
          PLAY: begin
            if (click_q) begin
              sel   <= cell_q;
              state <= DECODE;
            end
          end
          DECODE: begin
            if (sel != 9'd0 && (square & sel) == 9'd0) begin
              square       <= square | sel;
              square_color <= turn ? (square_color | sel) : square_color;
              state        <= CHECK;
            end else begin
              state <= PLAY;
            end
          end
          CHECK: begin
            if (has_line(mover_sq)) begin
              game_over    <= 1'b1;
              winner_valid <= 1'b1;
              winner_color <= turn;
              state        <= OVER;
            end else if (square == 9'h1FF) begin
              game_over <= 1'b1;
              state     <= OVER;
            end else begin
              turn  <= ~turn;
              state <= PLAY;
            end
          end
          OVER:    state <= OVER;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_board_ctl.sv
// Bench for board_ctl: a square-ownership model of the game, checked against the DUT
// every cycle, plus directed games with hand-worked expectations.
module tb_board_ctl;
  logic        pclk = 1'b0;
  logic        rst;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic        mouse_left;
  logic        start_en;
  logic        choice_en;
  logic        first_color;
  logic [8:0]  square;
  logic [8:0]  square_color;
  logic        turn;
  logic        game_over;
  logic        winner_valid;
  logic        winner_color;
  logic [2:0]  state;

  int tests = 0;
  int fails = 0;
  bit check_on = 1'b0;

  int         owner [9];
  logic       m_turn, m_over, m_wv, m_wc;
  logic [2:0] m_state;

  int lines [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                       '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};
  int xlo [3] = '{0, 343, 685};
  int xhi [3] = '{339, 681, 1023};
  int ylo [3] = '{0, 258, 516};
  int yhi [3] = '{251, 509, 767};

  always #5 pclk = ~pclk;

  board_ctl dut (
    .pclk(pclk), .rst(rst), .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
    .mouse_left(mouse_left), .start_en(start_en), .choice_en(choice_en),
    .first_color(first_color), .square(square), .square_color(square_color),
    .turn(turn), .game_over(game_over), .winner_valid(winner_valid),
    .winner_color(winner_color), .state(state)
  );

  task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [8:0] occMask();
    logic [8:0] m = 9'd0;
    for (int k = 0; k < 9; k++) if (owner[k] >= 0) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [8:0] colMask();
    logic [8:0] m = 9'd0;
    for (int k = 0; k < 9; k++) if (owner[k] == 1) m[k] = 1'b1;
    return m;
  endfunction

  always @(negedge pclk) begin
    if (check_on) begin
      checkOutput("square", square, occMask());
      checkOutput("square_color", square_color, colMask());
      checkOutput("turn", 9'(turn), 9'(m_turn));
      checkOutput("game_over", 9'(game_over), 9'(m_over));
      checkOutput("winner_valid", 9'(winner_valid), 9'(m_wv));
      checkOutput("winner_color", 9'(winner_color), 9'(m_wc));
      checkOutput("state", 9'(state), 9'(m_state));
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Square number 1..9 for a screen position, or -1 when it hits no square.
  function automatic int cellOf(input int x, input int y);
    int c, r;
    c = -1;
    r = -1;
    for (int i = 0; i < 3; i++) begin
      if (x >= xlo[i] && x <= xhi[i]) c = i;
      if (y >= ylo[i] && y <= yhi[i]) r = i;
    end
    if (c < 0 || r < 0) return -1;
    return r * 3 + c + 1;
  endfunction

  function automatic bit wins(input int c);
    for (int l = 0; l < 8; l++)
      if (owner[lines[l][0]-1] == c && owner[lines[l][1]-1] == c && owner[lines[l][2]-1] == c)
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit boardFull();
    for (int k = 0; k < 9; k++) if (owner[k] < 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clearModel();
    for (int k = 0; k < 9; k++) owner[k] = -1;
    m_over = 1'b0;
    m_wv   = 1'b0;
    m_wc   = 1'b0;
  endtask

  task automatic goIdle(input logic fc);
    first_color = fc;
    start_en    = 1'b0;
    choice_en   = 1'b0;
    mouse_left  = 1'b0;
    tick();
    clearModel();
    m_state = 3'd0;
    m_turn  = fc;
    tick();
  endtask

  task automatic startGame();
    start_en = 1'b1;
    tick();
    m_state = 3'd1;
    m_turn  = first_color;
    tick();
    tick();
  endtask

  // One click at (x,y) held for 'hold' cycles; abort 1 = choice_en, 2 = rst while in DECODE.
  task automatic applyStimulus(input int x, input int y, input int hold, input int abort);
    int k;
    int last;
    bit pending;
    bit placed;
    k       = cellOf(x, y);
    last    = ((hold > 4) ? hold : 4) + 1;
    pending = 1'b0;
    placed  = 1'b0;
    mouse_xpos = 12'(x);
    mouse_ypos = 12'(y);
    for (int i = 0; i <= last; i++) begin
      mouse_left = (i < hold);
      if (i == 2 && pending && abort == 1) choice_en = 1'b1;
      if (i == 2 && pending && abort == 2) rst = 1'b1;
      tick();
      case (i)
        1: if (m_state == 3'd1) begin
             m_state = 3'd2;
             pending = 1'b1;
           end
        2: if (pending) begin
             if (abort != 0) begin
               clearModel();
               m_state = 3'd0;
               m_turn  = (abort == 1) ? first_color : 1'b0;
               checkOutput("abort_state", 9'(state), 9'd0);
               checkOutput("abort_square", square, 9'd0);
               if (abort == 2) checkOutput("rst_turn", 9'(turn), 9'd0);
               else            checkOutput("choice_turn", 9'(turn), 9'(first_color));
               choice_en = 1'b0;
               rst       = 1'b0;
             end else if (k > 0 && owner[k-1] < 0) begin
               owner[k-1] = int'(m_turn);
               m_state    = 3'd3;
               placed     = 1'b1;
             end else begin
               m_state = 3'd1;
               pending = 1'b0;
             end
           end
        3: if (pending) begin
             if (abort != 0) begin
               m_state = 3'd1;
               m_turn  = first_color;
             end else if (placed) begin
               if (wins(int'(m_turn))) begin
                 m_over = 1'b1; m_wv = 1'b1; m_wc = m_turn; m_state = 3'd4;
               end else if (boardFull()) begin
                 m_over = 1'b1; m_state = 3'd4;
               end else begin
                 m_turn = ~m_turn; m_state = 3'd1;
               end
             end
           end
        default: ;
      endcase
    end
  endtask

  task automatic clickSq(input int k, input int hold);
    applyStimulus(170 + 342 * ((k - 1) % 3), 125 + 258 * ((k - 1) / 3), hold, 0);
  endtask

  task automatic randomClick(input int abort);
    int r, c, w, x, y, hold;
    r = int'($urandom_range(99, 0));
    c = int'($urandom_range(2, 0));
    w = int'($urandom_range(2, 0));
    x = int'($urandom_range(xhi[c], xlo[c]));
    y = int'($urandom_range(yhi[w], ylo[w]));
    if (r < 8)       x = (c == 0) ? int'($urandom_range(342, 340)) : int'($urandom_range(684, 682));
    else if (r < 16) y = (w == 0) ? int'($urandom_range(257, 252)) : int'($urandom_range(515, 510));
    else if (r < 21) x = int'($urandom_range(4095, 1024));
    else if (r < 26) y = int'($urandom_range(4095, 768));
    hold = (abort != 0) ? 1 : int'($urandom_range(6, 1));
    applyStimulus(x, y, hold, abort);
  endtask

  initial begin
    int ab;
    rst = 1'b1; start_en = 1'b0; choice_en = 1'b0; first_color = 1'b0;
    mouse_left = 1'b0; mouse_xpos = 12'd0; mouse_ypos = 12'd0;
    tick();
    clearModel();
    m_state = 3'd0;
    m_turn  = 1'b0;
    check_on = 1'b1;
    tick();
    checkOutput("reset_state", 9'(state), 9'd0);
    checkOutput("reset_square", square, 9'd0);
    checkOutput("reset_turn", 9'(turn), 9'd0);
    rst = 1'b0;

    // First move, repeated square, invalid positions, long hold.
    goIdle(1'b0);
    startGame();
    clickSq(3, 1);
    checkOutput("first_square", square, 9'h004);
    checkOutput("first_color", square_color, 9'h000);
    checkOutput("first_turn", 9'(turn), 9'd1);
    clickSq(3, 1);
    checkOutput("repeat_square", square, 9'h004);
    checkOutput("repeat_state", 9'(state), 9'd1);
    applyStimulus(341, 100, 1, 0);
    applyStimulus(1100, 100, 1, 0);
    checkOutput("invalid_square", square, 9'h004);
    clickSq(1, 100);
    checkOutput("held_square", square, 9'h005);
    checkOutput("held_color", square_color, 9'h001);
    checkOutput("held_turn", 9'(turn), 9'd0);

    // Blue wins on the 1-5-9 diagonal.
    goIdle(1'b0);
    startGame();
    clickSq(1, 1); clickSq(2, 1); clickSq(5, 1); clickSq(3, 1); clickSq(9, 1);
    checkOutput("win_over", 9'(game_over), 9'd1);
    checkOutput("win_valid", 9'(winner_valid), 9'd1);
    checkOutput("win_color", 9'(winner_color), 9'd0);
    checkOutput("win_square", square, 9'h117);
    checkOutput("win_sqcolor", square_color, 9'h006);
    clickSq(4, 1);
    checkOutput("over_ignore", square, 9'h117);

    // Draw: full board with no line.
    goIdle(1'b0);
    startGame();
    clickSq(1, 1); clickSq(2, 1); clickSq(3, 1); clickSq(5, 1); clickSq(4, 1);
    clickSq(7, 1); clickSq(8, 1); clickSq(9, 1); clickSq(6, 2);
    checkOutput("draw_over", 9'(game_over), 9'd1);
    checkOutput("draw_valid", 9'(winner_valid), 9'd0);
    checkOutput("draw_square", square, 9'h1FF);
    checkOutput("draw_sqcolor", square_color, 9'h152);

    // Aborts while a move is being decoded.
    goIdle(1'b1);
    startGame();
    clickSq(5, 1);
    applyStimulus(170, 125, 1, 1);
    clickSq(2, 1);
    applyStimulus(854, 641, 1, 2);
    clickSq(9, 3);

    // Random games.
    for (int g = 0; g < 14; g++) begin
      goIdle(1'($urandom_range(1, 0)));
      startGame();
      for (int m = 0; m < 30 && !m_over; m++) begin
        ab = ($urandom_range(39, 0) == 0) ? int'($urandom_range(2, 1)) : 0;
        randomClick(ab);
      end
      randomClick(0);
      randomClick(0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
